// File: rtl/truth_table_sweeper.sv
// Sweeps all sixteen ABCD vectors through a 4-input function under test.
// It captures the function's truth table and minterm count, then compares the table against a golden value.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED_TT   = 16'hE8F9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        F_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic [15:0] truth_table,
    output logic [4:0]  minterm_count,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        match
);

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_idx;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_tt;
    logic [4:0]     r_mc;
    logic           r_valid;
    logic           r_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: begin
                if (abort)                 w_next = S_IDLE;
                else if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)              w_next = S_IDLE;
                else if (r_idx == 4'd15) w_next = S_DONE;
                else                    w_next = S_SETTLE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // An abort drops the pending sample and invalidates the results. The partial table stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_tt    <= 16'd0;
            r_mc    <= 5'd0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= 4'd0;
                        r_cnt   <= '0;
                        r_tt    <= 16'd0;
                        r_mc    <= 5'd0;
                        r_valid <= 1'b0;
                        r_match <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_idx   <= 4'd0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_match <= 1'b0;
                    end else if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_idx   <= 4'd0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_match <= 1'b0;
                    end else begin
                        r_tt[r_idx] <= F_in;
                        r_mc        <= r_mc + {4'd0, F_in};
                        if (r_idx != 4'd15) begin
                            r_idx <= r_idx + 4'd1;
                            r_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_match <= (r_tt == EXPECTED_TT);
                    r_idx   <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign {A, B, C, D}  = r_idx;
    assign truth_table   = r_tt;
    assign minterm_count = r_mc;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign valid         = r_valid;
    assign match         = r_match & r_valid;

endmodule
